// File: rtl/serial_adder_pkg.sv
// Shared types for the digit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple slice; cmsb is the carry into the slice's top bit.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             cmsb
);

  assign {co, sum} = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  // The top sum bit is x^y^carry_in, so the incoming carry falls out without a second adder.
  assign cmsb = sum[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock,
// least-significant digit first, with a start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [31:0]      base;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_co;
  logic             dig_cmsb;

  assign base = 32'(cnt_q) * DIGIT;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x    (a_q[base +: DIGIT]),
    .y    (b_q[base +: DIGIT]),
    .ci   (carry_q),
    .sum  (dig_sum),
    .co   (dig_co),
    .cmsb (dig_cmsb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is folded into the operands here: a + ~b + ~cin.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[base +: DIGIT] = dig_sum;
        carry_d            = dig_co;
        if (cnt_q == CW'(N - 1)) begin
          cout_d  = dig_co;
          ovf_d   = dig_co ^ dig_cmsb;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench: 16/4 directed tests plus 8/8 and 8/1 random back-to-back chains.
module tb_serial_adder;

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } r16_t;

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } r8_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        m_start, m_sub, m_cin;
  logic [15:0] m_a, m_b;
  logic        m_busy, m_done, m_cout, m_ovf;
  logic [15:0] m_s;

  logic [1:0]  x_start, x_sub, x_cin, x_busy, x_done, x_cout, x_ovf;
  logic [7:0]  x_a [2];
  logic [7:0]  x_b [2];
  logic [7:0]  x_s [2];

  int nvec = 0;
  int nerr = 0;
  r16_t sb16 [$];
  r8_t  sb8  [$];

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .rst(rst), .start(m_start), .sub(m_sub), .a(m_a), .b(m_b), .cin(m_cin),
    .busy(m_busy), .done(m_done), .s(m_s), .cout(m_cout), .ovf(m_ovf)
  );

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut8
      serial_adder #(.WIDTH(8), .DIGIT(gi == 0 ? 8 : 1)) u_dut8 (
        .clk(clk), .rst(rst), .start(x_start[gi]), .sub(x_sub[gi]), .a(x_a[gi]), .b(x_b[gi]),
        .cin(x_cin[gi]), .busy(x_busy[gi]), .done(x_done[gi]), .s(x_s[gi]),
        .cout(x_cout[gi]), .ovf(x_ovf[gi])
      );
    end
  endgenerate

  function automatic r8_t model8(input logic sb, input logic [7:0] aa, input logic [7:0] bb,
                                 input logic ci);
    logic [7:0] bx;
    logic       cx;
    logic [8:0] full;
    r8_t        r;
    bx     = sb ? ~bb : bb;
    cx     = sb ? ~ci : ci;
    full   = {1'b0, aa} + {1'b0, bx} + {8'b0, cx};
    r.s    = full[7:0];
    r.cout = full[8];
    r.ovf  = (aa[7] == bx[7]) && (r.s[7] != aa[7]);
    return r;
  endfunction

  // Entry: #1 after a rising edge with the DUT idle or in its done cycle. Exit: in the done cycle
  // (or one cycle later when idle_after). poke >= 0 re-raises start with a=FFFF mid-run.
  task automatic op16(input string nm, input logic sb, input logic [15:0] aa, input logic [15:0] bb,
                      input logic ci, input logic [15:0] es, input logic ec, input logic eo,
                      input int poke, input bit idle_after);
    r16_t e, g;
    int   lat;
    e = {es, ec, eo};
    g = e;
    sb16.push_back(e);
    m_start = 1'b1; m_sub = sb; m_a = aa; m_b = bb; m_cin = ci;
    @(posedge clk); #1;
    m_start = 1'b0;
    m_a = 16'($urandom); m_b = 16'($urandom); m_sub = 1'($urandom); m_cin = 1'($urandom);
    lat = 0;
    while (m_done !== 1'b1 && lat < 20) begin
      nvec++;
      if (m_busy !== 1'b1) begin
        nerr++;
        $display("FAIL %s busy_in_run cycle=%0d got=%b want=1", nm, lat, m_busy);
      end
      m_start = (lat == poke);
      if (lat == poke) m_a = 16'hFFFF;
      @(posedge clk); #1;
      lat++;
    end
    m_start = 1'b0;
    nvec++;
    if (lat !== 4) begin
      nerr++;
      $display("FAIL %s latency got=%0d want=4", nm, lat);
    end
    if (m_done === 1'b1) begin
      nvec++;
      if (m_busy !== 1'b0) begin
        nerr++;
        $display("FAIL %s busy_with_done got=%b want=0", nm, m_busy);
      end
      g = sb16.pop_front();
      nvec++;
      if ({m_s, m_cout, m_ovf} !== g) begin
        nerr++;
        $display("FAIL %s result got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b",
                 nm, m_s, m_cout, m_ovf, g.s, g.cout, g.ovf);
      end
    end
    $display("op16 %s sub=%b a=%h b=%h cin=%b -> s=%h cout=%b ovf=%b lat=%0d",
             nm, sb, aa, bb, ci, m_s, m_cout, m_ovf, lat);
    if (idle_after) begin
      @(posedge clk); #1;
      nvec++;
      if (m_done !== 1'b0 || m_busy !== 1'b0 || m_s !== g.s) begin
        nerr++;
        $display("FAIL %s after_done got done=%b busy=%b s=%h want done=0 busy=0 s=%h",
                 nm, m_done, m_busy, m_s, g.s);
      end
    end
  endtask

  task automatic op8(input int k, input logic sb, input logic [7:0] aa, input logic [7:0] bb,
                     input logic ci, input bit idle_after);
    r8_t e, g;
    int  lat, n;
    n = (k == 0) ? 1 : 8;
    e = model8(sb, aa, bb, ci);
    g = e;
    sb8.push_back(e);
    x_start[k] = 1'b1; x_sub[k] = sb; x_a[k] = aa; x_b[k] = bb; x_cin[k] = ci;
    @(posedge clk); #1;
    x_start[k] = 1'b0; x_a[k] = 8'($urandom); x_b[k] = 8'($urandom);
    lat = 0;
    while (x_done[k] !== 1'b1 && lat < 20) begin
      nvec++;
      if (x_busy[k] !== 1'b1) begin
        nerr++;
        $display("FAIL n%0d busy_in_run cycle=%0d got=%b want=1", n, lat, x_busy[k]);
      end
      @(posedge clk); #1;
      lat++;
    end
    nvec++;
    if (lat !== n) begin
      nerr++;
      $display("FAIL n%0d latency got=%0d want=%0d", n, lat, n);
    end
    if (x_done[k] === 1'b1) begin
      g = sb8.pop_front();
      nvec++;
      if ({x_s[k], x_cout[k], x_ovf[k], x_busy[k]} !== {g, 1'b0}) begin
        nerr++;
        $display("FAIL n%0d result got s=%h cout=%b ovf=%b busy=%b want s=%h cout=%b ovf=%b busy=0",
                 n, x_s[k], x_cout[k], x_ovf[k], x_busy[k], g.s, g.cout, g.ovf);
      end
    end
    $display("op8 n=%0d sub=%b a=%h b=%h cin=%b -> s=%h cout=%b ovf=%b lat=%0d",
             n, sb, aa, bb, ci, x_s[k], x_cout[k], x_ovf[k], lat);
    if (idle_after) begin
      @(posedge clk); #1;
      nvec++;
      if (x_done[k] !== 1'b0 || x_busy[k] !== 1'b0) begin
        nerr++;
        $display("FAIL n%0d after_done got done=%b busy=%b want 0 0", n, x_done[k], x_busy[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({m_s, m_cout, m_ovf, m_busy, m_done} !== 20'h0) begin
      nerr++;
      $display("FAIL reset16 got s=%h cout=%b ovf=%b busy=%b done=%b want all 0",
               m_s, m_cout, m_ovf, m_busy, m_done);
    end
    for (int k = 0; k < 2; k++) begin
      nvec++;
      if ({x_s[k], x_cout[k], x_ovf[k], x_busy[k], x_done[k]} !== 12'h0) begin
        nerr++;
        $display("FAIL reset8_%0d got s=%h cout=%b ovf=%b busy=%b done=%b want all 0",
                 k, x_s[k], x_cout[k], x_ovf[k], x_busy[k], x_done[k]);
      end
    end
    $display("reset applied: s=%h busy=%b done=%b", m_s, m_busy, m_done);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    op16("add_5_6",     1'b0, 16'h0005, 16'h0006, 1'b0, 16'h000B, 1'b0, 1'b0, -1, 1'b1);
    op16("add_ffff_1",  1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, -1, 1'b1);
    op16("add_7fff_1",  1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, -1, 1'b1);
    op16("add_cin",     1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, -1, 1'b1);
  endtask

  task automatic test_sub();
    op16("sub_9_7_b1",  1'b1, 16'h0009, 16'h0007, 1'b1, 16'h0001, 1'b1, 1'b0, -1, 1'b1);
    op16("sub_3_5",     1'b1, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0, -1, 1'b1);
    op16("sub_8000_1",  1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, -1, 1'b1);
  endtask

  task automatic test_ignore_start();
    op16("ignore_start", 1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1, 1'b1);
  endtask

  task automatic test_reset_midrun();
    int seen;
    m_start = 1'b1; m_sub = 1'b0; m_a = 16'hABCD; m_b = 16'h1111; m_cin = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nvec++;
    if ({m_s, m_cout, m_ovf, m_busy, m_done} !== 20'h0) begin
      nerr++;
      $display("FAIL reset_midrun got s=%h cout=%b ovf=%b busy=%b done=%b want all 0",
               m_s, m_cout, m_ovf, m_busy, m_done);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (m_done === 1'b1 || m_busy === 1'b1) seen++;
    end
    nvec++;
    if (seen !== 0) begin
      nerr++;
      $display("FAIL reset_midrun_quiet got active_cycles=%0d want 0", seen);
    end
    $display("reset mid-run: s=%h busy=%b active_cycles=%0d", m_s, m_busy, seen);
    op16("after_reset", 1'b0, 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, -1, 1'b1);
  endtask

  task automatic test_back_to_back();
    op16("b2b_first",  1'b0, 16'h0A0A, 16'h0505, 1'b0, 16'h0F0F, 1'b0, 1'b0, -1, 1'b0);
    op16("b2b_second", 1'b0, 16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0, -1, 1'b1);
  endtask

  task automatic test_chain8(input int k);
    for (int i = 0; i < 12; i++) begin
      op8(k, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), i == 11);
    end
    op8(k, 1'b0, 8'h7F, 8'h01, 1'b0, 1'b1);
    op8(k, 1'b1, 8'h00, 8'h01, 1'b0, 1'b1);
  endtask

  initial begin
    m_start = 1'b0; m_sub = 1'b0; m_cin = 1'b0; m_a = '0; m_b = '0;
    x_start = '0; x_sub = '0; x_cin = '0;
    for (int k = 0; k < 2; k++) begin
      x_a[k] = '0;
      x_b[k] = '0;
    end
    rst = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    test_chain8(0);
    test_chain8(1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor. Processes a WIDTH-bit operand pair DIGIT bits per clock, least-significant digit first. It reports the sum or difference with carry-out and signed-overflow flags through a start/busy/done handshake. It is the sequential successor to the team's 4-bit combinational adder, used wherever area matters more than single-cycle latency.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- sub  in  1  0 = add, 1 = subtract; sampled with start.
- a  in  WIDTH  operand A, unsigned or two's complement; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- cin  in  1  carry-in (add) / borrow-in (sub); sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when s/cout/ovf become valid.
- s  out  WIDTH  result; held until the next accepted start.
- cout  out  1  add: carry-out; sub: 1 = no borrow.
- ovf  out  1  signed overflow of the result.

## Operation
- N = WIDTH/DIGIT digit steps.
- Add: {cout,s} = a + b + cin.
- Sub: s = a − b − cin. Implemented as a + ~b + ~cin. cout = final carry, so cout = 1 means no borrow.
- ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1. Taken from the final digit step.
- FSM states:
  - IDLE → RUN on start (when rst = 0).
  - RUN holds a digit counter 0..N−1. RUN → IDLE after step N−1.
- On accept, the block latches a, b (inverted if sub), the effective carry, and mode. The digit counter clears. s and the flags are not cleared at accept; they keep their old values until overwritten.
- Each RUN cycle:
  - adds the current DIGIT slice of both operands plus the carry register;
  - writes the sum slice into s at the same position;
  - updates the carry register.
- After step N−1, the block writes cout and ovf and pulses done.
- start while busy = 1 is ignored; latched operands are unaffected.
- Inputs other than start are don't-care except at acceptance.
- Reset values: s = 0, cout = 0, ovf = 0, busy = 0, done = 0, state IDLE, counter 0.
- rst wins over everything, including mid-RUN. The partial result is discarded and outputs go to their reset values.
- DIGIT = WIDTH gives N = 1: a single RUN cycle.

## Timing
- start sampled high at rising edge t while in IDLE.
- busy = 1 from after edge t through edge t+N.
- Digit i is written at edge t+1+i.
- After edge t+N: done = 1 for exactly one cycle, busy = 0, and s/cout/ovf are valid and stable.
- Latency from start edge to done visible: N cycles. Throughput: one operation per N+1 cycles.
- Back-to-back: start may be high in the done cycle. It is accepted at that edge, and the next done follows N cycles later.
- done and busy are never high in the same cycle.
- s may show mixed old/new digits while busy = 1; consumers use it only when done = 1 or afterward.

## Structure
- Package serial_adder_pkg: FSM state enum (IDLE, RUN).
- Width checks live in the module: WIDTH % DIGIT == 0 and DIGIT ≥ 1, enforced by an elaboration-time assertion.
- Sub-module digit_adder: combinational DIGIT-bit adder with inputs x, y, ci and outputs sum, co, and cmsb (carry into the top bit, used for ovf).
- One instance per serial_adder.
- The top level holds the FSM, counter, operand shift/index logic and result register.

## Test plan
All tests use WIDTH = 16, DIGIT = 4 (N = 4).
- Add a=0x0005, b=0x0006, cin=0 → s=0x000B, cout=0, ovf=0; done exactly 4 cycles after the start edge; busy high for cycles 1..4.
- Add a=0xFFFF, b=0x0001, cin=0 → s=0x0000, cout=1, ovf=0. Add a=0x7FFF, b=0x0001 → s=0x8000, cout=0, ovf=1.
- Sub a=0x0009, b=0x0007, cin=1 → s=0x0001, cout=1. Sub a=0x0003, b=0x0005, cin=0 → s=0xFFFE, cout=0, ovf=0.
- Start a=0x1234 + b=0x1111. Reassert start with a=0xFFFF at cycle 2 → ignored; result s=0x2345, single done.
- rst at cycle 2 of a run → all outputs 0, busy=0 next cycle, no done. A fresh start then completes normally.
- Back-to-back: second start (a=0x0100, b=0x0200, cin=0) in the done cycle → accepted; second done 4 cycles later with s=0x0300. Repeat with WIDTH=8, DIGIT=8 (N=1) and WIDTH=8, DIGIT=1 (N=8), using random operands checked against a reference sum.
